// File: rtl/dac_pacer_pkg.sv
// Shared types and constants for the DAC sample pacer.
package dac_pacer_pkg;

  localparam int unsigned SHIFT_WIDTH  = 24;
  // Sample width the pair struct is built with; DATA_WIDTH of the pacer must match.
  localparam int unsigned SAMPLE_WIDTH = 14;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] a;
    logic [SAMPLE_WIDTH-1:0] b;
  } sample_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } pacer_state_t;

  // Cycles the driver needs for one dual-channel serial transfer.
  function automatic int unsigned min_period(input int unsigned sclk_div,
                                             input int unsigned sync_dur,
                                             input int unsigned shift_width);
    return sclk_div * (2 * shift_width + sync_dur + 1);
  endfunction

endpackage

// File: rtl/dac_pacer_fifo.sv
// Single-clock sample-pair FIFO with occupancy output; no write-to-read bypass.
module dac_pacer_fifo
  import dac_pacer_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  sample_pair_t             wdata_i,
  input  logic                     pop_i,
  output sample_pair_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_q, wr_d, rd_q, rd_d;
  sample_pair_t  mem_q [Depth];
  logic          push_ok, pop_ok;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (PtrW + 1)'(Depth));
  assign empty_o = (wr_q == rd_q);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q[PtrW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (PtrW + 1)'(1);
    if (pop_ok)  rd_d = rd_q + (PtrW + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: pointer reset alone discards the contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces buffered A/B sample pairs to the AD56x3 driver as ce strobes at a clamped period.
// Build option: DAC_SAMPLE_PACER_ZERO_ON_UNDERFLOW_EN zeroes the data on underflow ticks.
module dac_sample_pacer
  import dac_pacer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SAMPLE_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned RATE_WIDTH  = 16,
  parameter int unsigned MIN_PERIOD  = min_period(2, 5, SHIFT_WIDTH),
  parameter int unsigned PRIME_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [RATE_WIDTH-1:0]         period,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_dataA,
  input  logic [DATA_WIDTH-1:0]         s_dataB,
  output logic                          ce,
  output logic [DATA_WIDTH-1:0]         dataA,
  output logic [DATA_WIDTH-1:0]         dataB,
  output logic                          underflow,
  output logic [15:0]                   underflowCnt,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned          LvlW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RATE_WIDTH-1:0] MinP    = RATE_WIDTH'(MIN_PERIOD);
  localparam logic [LvlW-1:0]       PrimeLvl = LvlW'(PRIME_LEVEL);

  pacer_state_t          state_q, state_d;
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0] eff_period;
  logic                  ce_q, ce_d;
  sample_pair_t          out_q, out_d;
  logic                  uf_q, uf_d;
  logic [15:0]           ucnt_q, ucnt_d;

  logic                  pop, full, empty;
  sample_pair_t          head, in_pair;
  logic [LvlW-1:0]       fifo_level;

  assign in_pair    = '{a: s_dataA, b: s_dataB};
  // Held low during reset so nothing is accepted while state is being cleared.
  assign s_ready    = ~full & ~reset;
  assign eff_period = (period < MinP) ? MinP : period;

  dac_pacer_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (s_valid & s_ready),
    .wdata_i (in_pair),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_d    = 1'b0;
    out_d   = out_q;
    uf_d    = 1'b0;
    ucnt_d  = ucnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = PRIME;
          ucnt_d  = '0;
        end
      end
      PRIME: begin
        cnt_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (fifo_level >= PrimeLvl) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // Tick: reload with the period in force right now.
          cnt_d = eff_period - RATE_WIDTH'(1);
          ce_d  = 1'b1;
          if (!empty) begin
            pop   = 1'b1;
            out_d = head;
          end else begin
            uf_d = 1'b1;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`ifdef DAC_SAMPLE_PACER_ZERO_ON_UNDERFLOW_EN
            out_d = '0;
`else
            out_d = out_q;
`endif
          end
        end else begin
          cnt_d = cnt_q - RATE_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      out_q   <= '0;
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      out_q   <= out_d;
      uf_q    <= uf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign ce           = ce_q;
  assign dataA        = out_q.a;
  assign dataB        = out_q.b;
  assign underflow    = uf_q;
  assign underflowCnt = ucnt_q;
  assign level        = fifo_level;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Scoreboard bench for dac_sample_pacer: a cycle-numbered reference model predicts strobes.
module tb_dac_sample_pacer;

  localparam int DW    = 14;
  localparam int DEPTH = 16;
  localparam int MINP  = 108;
  localparam int PRIME = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   period;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_dataA, s_dataB;
  logic          ce;
  logic [DW-1:0] dataA, dataB;
  logic          underflow;
  logic [15:0]   underflowCnt;
  logic [4:0]    level;

  dac_sample_pacer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_dataA      (s_dataA),
    .s_dataB      (s_dataB),
    .ce           (ce),
    .dataA        (dataA),
    .dataB        (dataB),
    .underflow    (underflow),
    .underflowCnt (underflowCnt),
    .level        (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_ce  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [15:0]   ucnt;
    logic          uf;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  pair_t m_q[$];
  exp_t  exp_q[$];
  int    m_mode;      // 0 idle, 1 waiting for prime level, 2 running
  int    m_next;      // absolute cycle number of the next tick
  int    m_ucnt;
  pair_t m_last;

  // Evaluated mid-cycle: decides what the coming clock edge does.
  always @(negedge clk) begin
    if (reset) begin
      m_q.delete();
      m_mode = 0;
      m_ucnt = 0;
      m_last = '0;
    end else begin
      bit    was_full;
      int    eff;
      pair_t p;
      exp_t  e;
      was_full = (m_q.size() >= DEPTH);
      check("s_ready", s_ready, !was_full);
      check("level", level, m_q.size());
      case (m_mode)
        0: if (enable) begin
          m_mode = 1;
          m_ucnt = 0;
        end
        1: if (!enable) m_mode = 0;
           else if (m_q.size() >= PRIME) begin
             m_mode = 2;
             m_next = cyc + 1;
           end
        default: if (!enable) m_mode = 0;
                 else if (cyc == m_next) begin
                   eff    = (int'(period) < MINP) ? MINP : int'(period);
                   m_next = cyc + eff;
                   if (m_q.size() > 0) begin
                     p      = m_q.pop_front();
                     m_last = p;
                     e.uf   = 1'b0;
                   end else begin
                     e.uf = 1'b1;
                     if (m_ucnt < 16'hFFFF) m_ucnt++;
`ifdef DAC_SAMPLE_PACER_ZERO_ON_UNDERFLOW_EN
                     p = '0;
`else
                     p = m_last;
`endif
                   end
                   e.cyc  = cyc;
                   e.ucnt = 16'(m_ucnt);
                   e.a    = p.a;
                   e.b    = p.b;
                   exp_q.push_back(e);
                 end
      endcase
      if (s_valid && !was_full) m_q.push_back('{a: s_dataA, b: s_dataB});
    end
  end

  // ---------------- monitor ----------------
  logic [DW-1:0] hold_a, hold_b;
  bit            want;
  exp_t          got;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_a = '0;
      hold_b = '0;
    end else begin
      want = (exp_q.size() > 0) && (int'(exp_q[0].cyc) + 1 == cyc);
      check("ce", ce, want);
      if (want) begin
        got    = exp_q.pop_front();
        hold_a = got.a;
        hold_b = got.b;
        check("underflow", underflow, got.uf);
        check("underflowCnt", underflowCnt, got.ucnt);
      end else begin
        check("underflow_idle", underflow, 0);
      end
      check("dataA", dataA, hold_a);
      check("dataB", dataB, hold_b);
      if (ce) n_ce++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit acc;
    s_valid = 1'b1;
    s_dataA = a;
    s_dataB = b;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = s_ready;
      step();
      if (acc) break;
      if (n == 2999) timeout("push_pair");
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_ces(input int k);
    int target;
    target = n_ce + k;
    for (int n = 0; n < 6000; n++) begin
      step();
      if (n_ce >= target) return;
    end
    timeout("wait_ces");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset   = 1'b1;
    enable  = 1'b0;
    period  = '0;
    s_valid = 1'b0;
    s_dataA = '0;
    s_dataB = '0;
    repeat (3) step();
    check("rst_s_ready", s_ready, 0);
    check("rst_ce", ce, 0);
    check("rst_dataA", dataA, 0);
    check("rst_dataB", dataB, 0);
    check("rst_underflow", underflow, 0);
    check("rst_underflowCnt", underflowCnt, 0);
    check("rst_level", level, 0);
    reset = 1'b0;
    step();

    // Eight ordered pairs at period 125.
    period = 16'd125;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push_pair(DW'(i + 1), DW'(100 + i));
    wait_ces(8);
    enable = 1'b0;
    step();

    // Clamped periods 10 and 0.
    period = 16'd10;
    for (int i = 0; i < 4; i++) push_pair(DW'($urandom), DW'($urandom));
    enable = 1'b1;
    wait_ces(2);
    period = 16'd0;
    wait_ces(2);
    enable = 1'b0;
    step();

    // Underflow: 4 pairs, 6 ticks.
    period = 16'd125;
    for (int i = 0; i < 4; i++) push_pair(DW'($urandom), DW'($urandom));
    enable = 1'b1;
    wait_ces(6);
    enable = 1'b0;
    check("underflowCnt_after6", underflowCnt, 2);
    step();

    // Fill while disabled.
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_dataA = DW'($urandom);
      s_dataB = DW'($urandom);
      step();
    end
    s_valid = 1'b0;
    check("fill_level", level, 16);
    check("fill_s_ready", s_ready, 0);

    // Period change mid-interval.
    period = 16'd125;
    enable = 1'b1;
    wait_ces(1);
    repeat (50) step();
    period = 16'd200;
    wait_ces(3);

    // Reset during RUN at level 5.
    for (int n = 0; n < 6000; n++) begin
      if (level == 5) break;
      step();
      if (n == 5999) timeout("wait_level5");
    end
    reset = 1'b1;
    #1;
    check("mid_rst_ce", ce, 0);
    check("mid_rst_dataA", dataA, 0);
    check("mid_rst_dataB", dataB, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_underflowCnt", underflowCnt, 0);
    repeat (2) step();
    reset = 1'b0;
    base  = n_ce;
    repeat (300) step();
    check("no_ce_unprimed", n_ce, base);

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      s_valid = ($urandom_range(0, 99) < 2);
      s_dataA = DW'($urandom);
      s_dataB = DW'($urandom);
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if ($urandom_range(0, 149) == 0) period = 16'($urandom_range(0, 250));
      step();
    end
    s_valid = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
